// File: rtl/argon_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : argon_alu_seq
// Brief    : Handshaked Argon ALU. Single-cycle arithmetic/logic/shift ops,
//            plus iterative MUL/DIV/MOD when ARGON_ALU_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module argon_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [4:0]       i_Op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_FlagLoad,
    input  logic [7:0]       i_FlagData,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Y,
    output logic [WIDTH-1:0] o_YHi,
    output logic [7:0]       o_Flags
);

    localparam int c_SHW  = $clog2(WIDTH);
    localparam int c_SHW1 = c_SHW + 1;
    localparam logic [c_SHW:0]    c_WIDTH_S = c_SHW1'(WIDTH);
    localparam logic [WIDTH-1:0]  c_ONE     = WIDTH'(1);

    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_ADC  = 5'd1;
    localparam logic [4:0] c_OP_SBC  = 5'd2;
    localparam logic [4:0] c_OP_CMP  = 5'd3;
    localparam logic [4:0] c_OP_INC  = 5'd4;
    localparam logic [4:0] c_OP_DEC  = 5'd5;
    localparam logic [4:0] c_OP_NAND = 5'd6;
    localparam logic [4:0] c_OP_AND  = 5'd7;
    localparam logic [4:0] c_OP_OR   = 5'd8;
    localparam logic [4:0] c_OP_NOR  = 5'd9;
    localparam logic [4:0] c_OP_XOR  = 5'd10;
    localparam logic [4:0] c_OP_LSH  = 5'd11;
    localparam logic [4:0] c_OP_RSH  = 5'd12;
    localparam logic [4:0] c_OP_ROL  = 5'd13;
    localparam logic [4:0] c_OP_ROR  = 5'd14;

    localparam int c_F_CARRY   = 0;
    localparam int c_F_ZERO    = 1;
    localparam int c_F_EQUAL   = 2;
    localparam int c_F_GREATER = 3;
    localparam int c_F_LESS    = 4;
    localparam int c_F_ERROR   = 5;

`ifdef ARGON_ALU_MULDIV_EN
    localparam logic [4:0] c_OP_MUL = 5'd16;
    localparam logic [4:0] c_OP_DIV = 5'd17;
    localparam logic [4:0] c_OP_MOD = 5'd18;
    localparam int c_F_DIVZERO = 6;
    localparam logic [c_SHW-1:0] c_CNT_LAST = c_SHW'(WIDTH - 1);
    localparam logic [c_SHW-1:0] c_CNT_ONE  = c_SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    // Flag register serves as both rF and the o_Flags snapshot; loads happen
    // only in IDLE where no result is being presented.
    logic [7:0]         flags_q, flags_d;
    logic               w_accept;

    logic [c_SHW-1:0]   w_shamt;
    logic [c_SHW:0]     w_rinv;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res_y;
    logic [7:0]         w_res_fl;
    logic               w_keep;
    logic               w_zero_en;

`ifdef ARGON_ALU_MULDIV_EN
    logic [WIDTH-1:0]   yhi_q, yhi_d;
    logic [WIDTH-1:0]   whi_q, whi_d;
    logic [WIDTH-1:0]   wlo_q, wlo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [c_SHW-1:0]   cnt_q, cnt_d;
    logic               mul_q, mul_d;
    logic               mod_q, mod_d;
    logic [WIDTH-1:0]   w_res_yhi;
    logic               w_iter;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dtmp;
    logic               w_dge;
    logic [WIDTH-1:0]   w_dsub;
    logic [WIDTH-1:0]   w_nhi;
    logic [WIDTH-1:0]   w_nlo;
`endif

    assign o_Ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && i_Ready);
    assign w_accept = i_Valid && o_Ready;
    assign o_Valid  = (state_q == S_DONE);
    assign o_Y      = y_q;
    assign o_Flags  = flags_q;
`ifdef ARGON_ALU_MULDIV_EN
    assign o_YHi    = yhi_q;
`else
    assign o_YHi    = '0;
`endif

    // Single-cycle result for the operation on the input port
    always_comb begin
        w_shamt   = i_B[c_SHW-1:0];
        w_rinv    = c_WIDTH_S - {1'b0, w_shamt};
        w_sum     = '0;
        w_res_y   = '0;
        w_res_fl  = '0;
        w_keep    = 1'b0;
        w_zero_en = 1'b1;
`ifdef ARGON_ALU_MULDIV_EN
        w_res_yhi = '0;
        w_iter    = 1'b0;
`endif
        case (i_Op)
            c_OP_ADD: begin
                w_sum                = {1'b0, i_A} + {1'b0, i_B};
                w_res_y              = w_sum[WIDTH-1:0];
                w_res_fl[c_F_CARRY]  = w_sum[WIDTH];
            end
            c_OP_ADC: begin
                w_sum                = {1'b0, i_A} + {1'b0, i_B} + {{WIDTH{1'b0}}, flags_q[c_F_CARRY]};
                w_res_y              = w_sum[WIDTH-1:0];
                w_res_fl[c_F_CARRY]  = w_sum[WIDTH];
            end
            c_OP_SBC: begin
                w_sum                = {1'b0, i_A} + {1'b0, ~i_B} + {{WIDTH{1'b0}}, flags_q[c_F_CARRY]};
                w_res_y              = w_sum[WIDTH-1:0];
                w_res_fl[c_F_CARRY]  = w_sum[WIDTH];
            end
            c_OP_CMP: begin
                w_keep                = 1'b1;
                w_zero_en             = 1'b0;
                w_res_fl[c_F_ZERO]    = (i_A == i_B);
                w_res_fl[c_F_EQUAL]   = (i_A == i_B);
                w_res_fl[c_F_GREATER] = (i_A > i_B);
                w_res_fl[c_F_LESS]    = (i_A < i_B);
            end
            c_OP_INC:  w_res_y = i_A + c_ONE;
            c_OP_DEC:  w_res_y = i_A - c_ONE;
            c_OP_NAND: w_res_y = ~(i_A & i_B);
            c_OP_AND:  w_res_y = i_A & i_B;
            c_OP_OR:   w_res_y = i_A | i_B;
            c_OP_NOR:  w_res_y = ~(i_A | i_B);
            c_OP_XOR:  w_res_y = i_A ^ i_B;
            c_OP_LSH:  w_res_y = i_A << w_shamt;
            c_OP_RSH:  w_res_y = i_A >> w_shamt;
            // A shift by WIDTH yields zero, so a rotate by 0 returns A
            c_OP_ROL:  w_res_y = (i_A << w_shamt) | (i_A >> w_rinv);
            c_OP_ROR:  w_res_y = (i_A >> w_shamt) | (i_A << w_rinv);
`ifdef ARGON_ALU_MULDIV_EN
            c_OP_MUL:  w_iter = 1'b1;
            c_OP_DIV, c_OP_MOD: begin
                if (i_B == '0) begin
                    w_res_y               = (i_Op == c_OP_DIV) ? '1 : i_A;
                    w_res_yhi             = i_A;
                    w_res_fl[c_F_ERROR]   = 1'b1;
                    w_res_fl[c_F_DIVZERO] = 1'b1;
                    w_zero_en             = 1'b0;
                end else begin
                    w_iter = 1'b1;
                end
            end
`endif
            default: begin
                w_res_fl[c_F_ERROR] = 1'b1;
                w_zero_en           = 1'b0;
            end
        endcase
        if (w_zero_en) begin
            w_res_fl[c_F_ZERO] = (w_res_y == '0);
        end
    end

`ifdef ARGON_ALU_MULDIV_EN
    // One shift-add (MUL) or restoring-divide step per EXEC cycle
    always_comb begin
        w_madd = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, opnd_q} : '0);
        w_dtmp = {whi_q, wlo_q[WIDTH-1]};
        w_dge  = (w_dtmp >= {1'b0, opnd_q});
        w_dsub = w_dtmp[WIDTH-1:0] - opnd_q;
        if (mul_q) begin
            w_nhi = w_madd[WIDTH:1];
            w_nlo = {w_madd[0], wlo_q[WIDTH-1:1]};
        end else begin
            w_nhi = w_dge ? w_dsub : w_dtmp[WIDTH-1:0];
            w_nlo = {wlo_q[WIDTH-2:0], w_dge};
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        flags_d = flags_q;
`ifdef ARGON_ALU_MULDIV_EN
        yhi_d   = yhi_q;
        whi_d   = whi_q;
        wlo_d   = wlo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        mod_d   = mod_q;
`endif
        case (state_q)
            S_DONE: begin
                if (i_Ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ARGON_ALU_MULDIV_EN
            S_EXEC: begin
                whi_d = w_nhi;
                wlo_d = w_nlo;
                cnt_d = cnt_q + c_CNT_ONE;
                if (cnt_q == c_CNT_LAST) begin
                    state_d = S_DONE;
                    yhi_d   = w_nhi;
                    flags_d = '0;
                    if (mul_q) begin
                        y_d                = w_nlo;
                        flags_d[c_F_CARRY] = (w_nhi != '0);
                        flags_d[c_F_ZERO]  = (w_nlo == '0);
                    end else if (mod_q) begin
                        y_d                = w_nhi;
                        flags_d[c_F_ZERO]  = (w_nhi == '0);
                    end else begin
                        y_d                = w_nlo;
                        flags_d[c_F_ZERO]  = (w_nlo == '0);
                    end
                end
            end
`endif
            default: ;
        endcase

        // Accept in DONE overrides the retire-to-IDLE transition above
        if (w_accept) begin
`ifdef ARGON_ALU_MULDIV_EN
            if (w_iter) begin
                state_d = S_EXEC;
                cnt_d   = '0;
                mul_d   = (i_Op == c_OP_MUL);
                mod_d   = (i_Op == c_OP_MOD);
                whi_d   = '0;
                wlo_d   = (i_Op == c_OP_MUL) ? i_B : i_A;
                opnd_d  = (i_Op == c_OP_MUL) ? i_A : i_B;
            end else
`endif
            begin
                state_d = S_DONE;
                flags_d = w_res_fl;
                if (!w_keep) begin
                    y_d   = w_res_y;
`ifdef ARGON_ALU_MULDIV_EN
                    yhi_d = w_res_yhi;
`endif
                end
            end
        end else if (i_FlagLoad && (state_q == S_IDLE)) begin
            flags_d = i_FlagData;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            flags_q <= '0;
`ifdef ARGON_ALU_MULDIV_EN
            yhi_q   <= '0;
            whi_q   <= '0;
            wlo_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            mod_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            flags_q <= flags_d;
`ifdef ARGON_ALU_MULDIV_EN
            yhi_q   <= yhi_d;
            whi_q   <= whi_d;
            wlo_q   <= wlo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            mod_q   <= mod_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_argon_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_argon_alu_seq
// Brief    : Self-checking bench for argon_alu_seq (WIDTH=16) against a
//            behavioural arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_argon_alu_seq;

`ifdef ARGON_ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_op = '0;
    logic [15:0] i_a = '0;
    logic [15:0] i_b = '0;
    logic        i_flagload = 1'b0;
    logic [7:0]  i_flagdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_y;
    logic [15:0] o_yhi;
    logic [7:0]  o_flags;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_rf  = '0;
    logic [15:0] m_y   = '0;
    logic [15:0] m_yhi = '0;

    argon_alu_seq #(.WIDTH(16)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Valid    (i_valid),
        .o_Ready    (o_ready),
        .i_Op       (i_op),
        .i_A        (i_a),
        .i_B        (i_b),
        .i_FlagLoad (i_flagload),
        .i_FlagData (i_flagdata),
        .o_Valid    (o_valid),
        .i_Ready    (i_ready),
        .o_Y        (o_y),
        .o_YHi      (o_yhi),
        .o_Flags    (o_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: plain integer arithmetic; updates model rF / last result
    function automatic void model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] y, output logic [15:0] yhi,
                                  output logic [7:0] fl, output int lat);
        longint s;
        int     sh;
        logic [15:0] r;
        bit     zero_ok;
        bit     ill;
        y = '0; yhi = '0; fl = '0; lat = 1; zero_ok = 1; ill = 0;
        sh = int'(b) % 16;
        r  = a;
        case (op)
            5'd0: begin s = longint'(a) + longint'(b); y = 16'(s); fl[0] = (s > 65535); end
            5'd1: begin s = longint'(a) + longint'(b) + longint'(m_rf[0]); y = 16'(s); fl[0] = (s > 65535); end
            5'd2: begin
                s = longint'(a) - longint'(b) - (m_rf[0] ? 0 : 1);
                y = 16'(s); fl[0] = (s >= 0);
            end
            5'd3: begin
                y = m_y; yhi = m_yhi; zero_ok = 0;
                fl[1] = (a == b); fl[2] = (a == b); fl[3] = (a > b); fl[4] = (a < b);
            end
            5'd4: y = 16'(longint'(a) + 1);
            5'd5: y = 16'(longint'(a) - 1);
            5'd6: y = ~(a & b);
            5'd7: y = a & b;
            5'd8: y = a | b;
            5'd9: y = ~(a | b);
            5'd10: y = a ^ b;
            5'd11: y = a << sh;
            5'd12: y = a >> sh;
            5'd13: begin repeat (sh) r = {r[14:0], r[15]}; y = r; end
            5'd14: begin repeat (sh) r = {r[0], r[15:1]}; y = r; end
            5'd16, 5'd17, 5'd18: begin
                if (!MULDIV) begin
                    ill = 1;
                end else if (op == 5'd16) begin
                    s = longint'(a) * longint'(b);
                    y = 16'(s); yhi = 16'(s / 65536); fl[0] = (yhi != 0); lat = 17;
                end else if (b == 0) begin
                    y = (op == 5'd17) ? 16'hFFFF : a; yhi = a; fl = 8'h60; zero_ok = 0;
                end else begin
                    y = (op == 5'd17) ? a / b : a % b; yhi = a % b; lat = 17;
                end
            end
            default: ill = 1;
        endcase
        if (ill) begin
            y = '0; yhi = '0; fl = 8'h20; zero_ok = 0;
        end
        if (zero_ok) fl[1] = (y == 0);
        if (!MULDIV) yhi = '0;
        m_rf = fl;
        m_y  = y;
        m_yhi = yhi;
    endfunction

    // Drives one transfer and waits (bounded) for its result; leaves it held
    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic fld, input logic [7:0] fdat,
                          output logic rdy, output logic [15:0] y, output logic [15:0] yhi,
                          output logic [7:0] fl, output int lat);
        @(negedge clk);
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1; i_ready = 1'b1;
        i_flagload = fld; i_flagdata = fdat;
        #1 rdy = o_ready;
        @(posedge clk); #1;
        i_valid = 1'b0; i_ready = 1'b0; i_flagload = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        y = o_y; yhi = o_yhi; fl = o_flags;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        m_rf = '0; m_y = '0; m_yhi = '0;
        checks += 5;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        if (o_y !== 16'h0)    begin failures++; $display("FAIL reset_y got %h exp 0000", o_y); end
        if (o_yhi !== 16'h0)  begin failures++; $display("FAIL reset_yhi got %h exp 0000", o_yhi); end
        if (o_flags !== 8'h0) begin failures++; $display("FAIL reset_flags got %h exp 00", o_flags); end
    endtask

    task automatic test_directed;
        logic rdy; logic [15:0] y, yhi, ey, eyhi; logic [7:0] fl, efl; int lat, elat;
        run_op(5'd0, 16'hFFFF, 16'h0001, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd0, 16'hFFFF, 16'h0001, ey, eyhi, efl, elat);
        checks += 2;
        if (y !== 16'h0000) begin failures++; $display("FAIL add_carry_y got %h exp 0000", y); end
        if (fl !== 8'h03)   begin failures++; $display("FAIL add_carry_flags got %h exp 03", fl); end
        run_op(5'd1, 16'h0000, 16'h0000, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd1, 16'h0000, 16'h0000, ey, eyhi, efl, elat);
        checks += 2;
        if (y !== 16'h0001) begin failures++; $display("FAIL adc_y got %h exp 0001", y); end
        if (fl !== 8'h00)   begin failures++; $display("FAIL adc_flags got %h exp 00", fl); end
        run_op(5'd13, 16'h8001, 16'h0000, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd13, 16'h8001, 16'h0000, ey, eyhi, efl, elat);
        checks++;
        if (y !== 16'h8001) begin failures++; $display("FAIL rol0 got %h exp 8001", y); end
        run_op(5'd13, 16'h8001, 16'h0001, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd13, 16'h8001, 16'h0001, ey, eyhi, efl, elat);
        checks++;
        if (y !== 16'h0003) begin failures++; $display("FAIL rol1 got %h exp 0003", y); end
`ifdef ARGON_ALU_MULDIV_EN
        run_op(5'd16, 16'h1234, 16'h5678, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd16, 16'h1234, 16'h5678, ey, eyhi, efl, elat);
        checks += 4;
        if (lat !== 17)       begin failures++; $display("FAIL mul_latency got %0d exp 17", lat); end
        if (yhi !== 16'h0626) begin failures++; $display("FAIL mul_yhi got %h exp 0626", yhi); end
        if (y !== 16'h0060)   begin failures++; $display("FAIL mul_y got %h exp 0060", y); end
        if (fl !== 8'h01)     begin failures++; $display("FAIL mul_flags got %h exp 01", fl); end
        run_op(5'd17, 16'd100, 16'd7, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd17, 16'd100, 16'd7, ey, eyhi, efl, elat);
        checks += 3;
        if (lat !== 17)    begin failures++; $display("FAIL div_latency got %0d exp 17", lat); end
        if (y !== 16'd14)  begin failures++; $display("FAIL div_q got %0d exp 14", y); end
        if (yhi !== 16'd2) begin failures++; $display("FAIL div_r got %0d exp 2", yhi); end
        run_op(5'd17, 16'd5, 16'd0, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd17, 16'd5, 16'd0, ey, eyhi, efl, elat);
        checks += 4;
        if (lat !== 1)        begin failures++; $display("FAIL div0_latency got %0d exp 1", lat); end
        if (y !== 16'hFFFF)   begin failures++; $display("FAIL div0_y got %h exp ffff", y); end
        if (yhi !== 16'd5)    begin failures++; $display("FAIL div0_yhi got %h exp 0005", yhi); end
        if (fl !== 8'h60)     begin failures++; $display("FAIL div0_flags got %h exp 60", fl); end
`else
        run_op(5'd16, 16'h1234, 16'h5678, 0, 0, rdy, y, yhi, fl, lat);
        model(5'd16, 16'h1234, 16'h5678, ey, eyhi, efl, elat);
        checks += 3;
        if (lat !== 1)      begin failures++; $display("FAIL op16_latency got %0d exp 1", lat); end
        if (y !== 16'h0000) begin failures++; $display("FAIL op16_y got %h exp 0000", y); end
        if (fl !== 8'h20)   begin failures++; $display("FAIL op16_flags got %h exp 20", fl); end
`endif
    endtask

    task automatic test_random(input int n);
        logic rdy; logic [15:0] a, b, y, yhi, ey, eyhi; logic [7:0] fl, efl; logic [4:0] op;
        int lat, elat;
        for (int k = 0; k < n; k++) begin
            op = 5'($urandom_range(0, 18));
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(15, 31));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 5) == 0) b = a;
            model(op, a, b, ey, eyhi, efl, elat);
            run_op(op, a, b, 0, 0, rdy, y, yhi, fl, lat);
            checks += 5;
            if (rdy !== 1'b1) begin failures++; $display("FAIL rand[%0d] op=%0d ready got %b exp 1", k, op, rdy); end
            if (lat !== elat) begin failures++; $display("FAIL rand[%0d] op=%0d latency got %0d exp %0d", k, op, lat, elat); end
            if (y !== ey)     begin failures++; $display("FAIL rand[%0d] op=%0d a=%h b=%h y got %h exp %h", k, op, a, b, y, ey); end
            if (yhi !== eyhi) begin failures++; $display("FAIL rand[%0d] op=%0d a=%h b=%h yhi got %h exp %h", k, op, a, b, yhi, eyhi); end
            if (fl !== efl)   begin failures++; $display("FAIL rand[%0d] op=%0d a=%h b=%h flags got %h exp %h", k, op, a, b, fl, efl); end
        end
    endtask

    task automatic test_backpressure;
        logic rdy; logic [15:0] y, yhi, ey, eyhi; logic [7:0] fl, efl; int lat, elat;
        model(5'd0, 16'd3, 16'd4, ey, eyhi, efl, elat);
        run_op(5'd0, 16'd3, 16'd4, 0, 0, rdy, y, yhi, fl, lat);
        checks++;
        if (y !== 16'd7) begin failures++; $display("FAIL bp_y got %h exp 0007", y); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks += 3;
            if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", c, o_valid); end
            if (o_y !== 16'd7)    begin failures++; $display("FAIL bp_hold_y[%0d] got %h exp 0007", c, o_y); end
            if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready[%0d] got %b exp 0", c, o_ready); end
        end
        model(5'd0, 16'd10, 16'd20, ey, eyhi, efl, elat);
        run_op(5'd0, 16'd10, 16'd20, 0, 0, rdy, y, yhi, fl, lat);
        checks += 3;
        if (rdy !== 1'b1) begin failures++; $display("FAIL bp_release_ready got %b exp 1", rdy); end
        if (lat !== 1)    begin failures++; $display("FAIL bp_release_latency got %0d exp 1", lat); end
        if (y !== 16'd30) begin failures++; $display("FAIL bp_release_y got %h exp 001e", y); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a, b, ey, eyhi; logic [7:0] efl; logic [4:0] op; int elat;
        @(negedge clk);
        i_valid = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            op = 5'($urandom_range(0, 14));
            a = 16'($urandom); b = 16'($urandom);
            i_op = op; i_a = a; i_b = b;
            model(op, a, b, ey, eyhi, efl, elat);
            @(posedge clk); #1;
            checks += 3;
            if (o_valid !== 1'b1) begin failures++; $display("FAIL b2b[%0d] valid got %b exp 1", k, o_valid); end
            if (o_y !== ey)       begin failures++; $display("FAIL b2b[%0d] op=%0d y got %h exp %h", k, op, o_y, ey); end
            if (o_flags !== efl)  begin failures++; $display("FAIL b2b[%0d] op=%0d flags got %h exp %h", k, op, o_flags, efl); end
            @(negedge clk);
        end
        i_valid = 1'b0; i_ready = 1'b0;
    endtask

    task automatic test_flagload;
        logic rdy; logic [15:0] y, yhi, ey, eyhi; logic [7:0] fl, efl; int lat, elat;
        @(negedge clk); i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL retire_valid got %b exp 0", o_valid); end
        @(negedge clk); i_flagload = 1'b1; i_flagdata = 8'h01;
        @(posedge clk); #1 i_flagload = 1'b0;
        m_rf = 8'h01;
        model(5'd1, 16'h0000, 16'h0000, ey, eyhi, efl, elat);
        run_op(5'd1, 16'h0000, 16'h0000, 0, 0, rdy, y, yhi, fl, lat);
        checks += 2;
        if (y !== 16'h0001) begin failures++; $display("FAIL fload_adc_y got %h exp 0001", y); end
        if (y !== ey)       begin failures++; $display("FAIL fload_adc_model got %h exp %h", y, ey); end
        @(negedge clk); i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
        model(5'd0, 16'h0000, 16'h0000, ey, eyhi, efl, elat);
        run_op(5'd0, 16'h0000, 16'h0000, 1, 8'h01, rdy, y, yhi, fl, lat);
        checks++;
        if (fl !== 8'h02) begin failures++; $display("FAIL fload_vs_accept_flags got %h exp 02", fl); end
        model(5'd1, 16'h0000, 16'h0000, ey, eyhi, efl, elat);
        run_op(5'd1, 16'h0000, 16'h0000, 0, 0, rdy, y, yhi, fl, lat);
        checks++;
        if (y !== 16'h0000) begin failures++; $display("FAIL fload_ignored_adc_y got %h exp 0000", y); end
    endtask

    task automatic test_reset_midop;
        logic rdy; logic [15:0] y, yhi, ey, eyhi; logic [7:0] fl, efl; int lat, elat;
        @(negedge clk);
        i_op = MULDIV ? 5'd16 : 5'd0; i_a = 16'h1234; i_b = 16'h5678;
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1 i_valid = 1'b0; i_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks += 4;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b exp 0", o_valid); end
        if (o_flags !== 8'h0) begin failures++; $display("FAIL rstmid_flags got %h exp 00", o_flags); end
        if (o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got %b exp 1", o_ready); end
        if (o_y !== 16'h0)    begin failures++; $display("FAIL rstmid_y got %h exp 0000", o_y); end
        @(negedge clk); rst = 1'b0;
        m_rf = '0; m_y = '0; m_yhi = '0;
        model(5'd0, 16'd1, 16'd1, ey, eyhi, efl, elat);
        run_op(5'd0, 16'd1, 16'd1, 0, 0, rdy, y, yhi, fl, lat);
        checks += 2;
        if (y !== 16'd2) begin failures++; $display("FAIL rstmid_add_y got %h exp 0002", y); end
        if (lat !== 1)   begin failures++; $display("FAIL rstmid_add_latency got %0d exp 1", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(80);
        test_backpressure();
        test_back_to_back();
        test_flagload();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
